// File: rtl/ysyx_22050499_mdu.sv
// Iterative RV M-extension multiply/divide unit.
// One bit per cycle shift-add multiply and restoring divide.
module ysyx_22050499_mdu #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

    localparam logic [XLEN-1:0]  MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN-1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic [XLEN-1:0]   res_q, res_d;

    logic              sgn_a, sgn_b, neg_a, neg_b, res_neg;
    logic [XLEN-1:0]   mag_a, mag_b, addend, div_v;
    logic [XLEN:0]     sum_w, shf_w, diff_w;
    logic [2*XLEN-1:0] full_w, fullv_w;

    assign in_ready  = (state_q == IDLE) & rst_n;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = res_q;

    // operand sign handling and per-iteration datapath terms
    always_comb begin
        sgn_a   = op[2] ? ~op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10);
        sgn_b   = op[2] ? ~op[0] : (op[1:0] == 2'b01);
        neg_a   = sgn_a & src_a[XLEN-1];
        neg_b   = sgn_b & src_b[XLEN-1];
        mag_a   = neg_a ? ('0 - src_a) : src_a;
        mag_b   = neg_b ? ('0 - src_b) : src_b;
        res_neg = (op[2] & op[1]) ? neg_a : (neg_a ^ neg_b);
        addend  = lo_q[0] ? mcand_q : '0;
        sum_w   = {1'b0, acc_q} + {1'b0, addend};
        shf_w   = {acc_q, lo_q[XLEN-1]};
        diff_w  = shf_w - {1'b0, mcand_q};
        full_w  = {acc_q, lo_q};
        fullv_w = neg_q ? ('0 - full_w) : full_w;
        div_v   = op_q[1] ? acc_q : lo_q;
        div_v   = neg_q ? ('0 - div_v) : div_v;
    end

    // next-state and datapath update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        neg_d   = neg_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        res_d   = res_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_d    = op;
                        neg_d   = res_neg;
                        mcand_d = mag_b;
                        acc_d   = '0;
                        lo_d    = mag_a;
                        cnt_d   = '0;
                        if (op[2] && src_b == '0) begin
                            res_d   = op[1] ? src_a : '1;
                            state_d = DONE;
                        end else if (op[2] && !op[0] && src_a == MIN && src_b == '1) begin
                            res_d   = op[1] ? '0 : src_a;
                            state_d = DONE;
                        end else begin
                            state_d = CALC;
                        end
                    end
                end
                CALC: begin
                    if (op_q[2]) begin
                        if (!diff_w[XLEN]) begin
                            acc_d = diff_w[XLEN-1:0];
                            lo_d  = {lo_q[XLEN-2:0], 1'b1};
                        end else begin
                            acc_d = shf_w[XLEN-1:0];
                            lo_d  = {lo_q[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        acc_d = sum_w[XLEN:1];
                        lo_d  = {sum_w[0], lo_q[XLEN-1:1]};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) state_d = FIX;
                end
                FIX: begin
                    if (op_q[2])
                        res_d = div_v;
                    else if (op_q[1:0] == 2'b00)
                        res_d = fullv_w[XLEN-1:0];
                    else
                        res_d = fullv_w[2*XLEN-1:XLEN];
                    state_d = DONE;
                end
                DONE: begin
                    if (out_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // state and datapath registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            mcand_q <= '0;
            acc_q   <= '0;
            lo_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            res_q   <= res_d;
        end
    end

endmodule

// File: tb/tb_ysyx_22050499_mdu.sv
// Directed self-checking bench for ysyx_22050499_mdu.
// Inputs driven and outputs sampled on the falling edge.
module tb_ysyx_22050499_mdu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'd0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        busy;

    int checks = 0;
    int failures = 0;

    ysyx_22050499_mdu #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .src_a(src_a), .src_b(src_b), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    // drive one request from a falling edge; wait (bounded) for out_valid
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output bit rdy_seen);
        in_valid = 1'b1; op = o; src_a = a; src_b = b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; op = ~o; src_a = ~a; src_b = b ^ 32'h5a5a5a5a;
        lat = 1; rdy_seen = 1'b0;
        while (out_valid !== 1'b1 && lat < 100) begin
            if (in_ready !== 1'b0) rdy_seen = 1'b1;
            @(posedge clk); @(negedge clk); lat++;
        end
        if (in_ready !== 1'b0) rdy_seen = 1'b1;
        res = result;
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        checks++; if (result !== 32'h0) begin failures++; $display("FAIL rst_result got %h exp 0", result); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got %b exp 0", busy); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_mul();
        logic [31:0] r; int l; bit s;
        run_op(3'b000, 32'd7, 32'hFFFFFFFD, r, l, s);
        checks++; if (r !== 32'hFFFFFFEB) begin failures++; $display("FAIL mul_neg got %h exp ffffffeb", r); end
        checks++; if (l != 34) begin failures++; $display("FAIL mul_latency got %0d exp 34", l); end
        checks++; if (s !== 1'b0) begin failures++; $display("FAIL mul_in_ready_busy got %b exp 0", s); end
        take();
    endtask

    task automatic test_mulh();
        logic [31:0] r; int l; bit s;
        run_op(3'b001, 32'h80000000, 32'h80000000, r, l, s);
        checks++; if (r !== 32'h40000000 || l >= 100) begin failures++; $display("FAIL mulh got %h exp 40000000", r); end
        take();
        run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, r, l, s);
        checks++; if (r !== 32'hFFFFFFFE || l >= 100) begin failures++; $display("FAIL mulhu got %h exp fffffffe", r); end
        take();
        run_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, r, l, s);
        checks++; if (r !== 32'hFFFFFFFF || l >= 100) begin failures++; $display("FAIL mulhsu got %h exp ffffffff", r); end
        take();
    endtask

    task automatic test_div();
        logic [31:0] r; int l; bit s;
        run_op(3'b100, 32'hFFFFFFF9, 32'd2, r, l, s);
        checks++; if (r !== 32'hFFFFFFFD || l != 34) begin failures++; $display("FAIL div_neg got %h lat %0d exp fffffffd lat 34", r, l); end
        take();
        run_op(3'b110, 32'hFFFFFFF9, 32'd2, r, l, s);
        checks++; if (r !== 32'hFFFFFFFF || l >= 100) begin failures++; $display("FAIL rem_neg got %h exp ffffffff", r); end
        take();
        run_op(3'b101, 32'd100, 32'd7, r, l, s);
        checks++; if (r !== 32'd14 || l >= 100) begin failures++; $display("FAIL divu got %h exp 0000000e", r); end
        take();
        run_op(3'b111, 32'd100, 32'd7, r, l, s);
        checks++; if (r !== 32'd2 || l >= 100) begin failures++; $display("FAIL remu got %h exp 00000002", r); end
        take();
        run_op(3'b110, 32'd7, 32'hFFFFFFFE, r, l, s);
        checks++; if (r !== 32'd1 || l >= 100) begin failures++; $display("FAIL rem_negdiv got %h exp 00000001", r); end
        take();
    endtask

    task automatic test_special();
        logic [31:0] r; int l; bit s;
        run_op(3'b100, 32'd5, 32'd0, r, l, s);
        checks++; if (r !== 32'hFFFFFFFF || l != 1) begin failures++; $display("FAIL div_by_zero got %h lat %0d exp ffffffff lat 1", r, l); end
        take();
        run_op(3'b111, 32'd5, 32'd0, r, l, s);
        checks++; if (r !== 32'd5 || l != 1) begin failures++; $display("FAIL remu_by_zero got %h lat %0d exp 00000005 lat 1", r, l); end
        take();
        run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, r, l, s);
        checks++; if (r !== 32'h80000000 || l != 1) begin failures++; $display("FAIL div_ovf got %h lat %0d exp 80000000 lat 1", r, l); end
        take();
        run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, r, l, s);
        checks++; if (r !== 32'h0 || l != 1) begin failures++; $display("FAIL rem_ovf got %h lat %0d exp 0 lat 1", r, l); end
        take();
    endtask

    task automatic test_back_to_back();
        logic [31:0] r; int l; bit s; bit bad;
        run_op(3'b101, 32'd100, 32'd7, r, l, s);
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || result !== 32'd14 || in_ready !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad) begin failures++; $display("FAIL backpressure_hold got %h ov %b exp 0000000e ov 1", result, out_valid); end
        take();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL post_handshake got rdy %b ov %b exp rdy 1 ov 0", in_ready, out_valid); end
        run_op(3'b011, 32'h12345678, 32'h9ABCDEF0, r, l, s);
        checks++; if (r !== 32'h0B00EA4E || l != 34) begin failures++; $display("FAIL b2b_mulhu got %h lat %0d exp 0b00ea4e lat 34", r, l); end
        take();
        run_op(3'b110, 32'hFFFFFF9C, 32'd7, r, l, s);
        checks++; if (r !== 32'hFFFFFFFE || l >= 100) begin failures++; $display("FAIL b2b_rem got %h exp fffffffe", r); end
        take();
    endtask

    task automatic test_flush();
        logic [31:0] prev, r; int l; bit s; bit seen;
        prev = result;
        in_valid = 1'b1; op = 3'b101; src_a = 32'd1000; src_b = 32'd3;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL flush_idle got busy %b rdy %b exp busy 0 rdy 1", busy, in_ready); end
        checks++; if (result !== prev) begin failures++; $display("FAIL flush_result got %h exp %h", result, prev); end
        seen = 1'b0;
        repeat (40) begin @(negedge clk); if (out_valid !== 1'b0) seen = 1'b1; end
        checks++; if (seen) begin failures++; $display("FAIL flush_no_result got out_valid 1 exp 0"); end
        flush = 1'b1; in_valid = 1'b1; op = 3'b000; src_a = 32'd2; src_b = 32'd2;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_priority got busy %b exp 0", busy); end
        in_valid = 1'b1; op = 3'b101; src_a = 32'd1000; src_b = 32'd3;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_mid_ready got %b exp 0", in_ready); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (result !== 32'h0 || busy !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL reset_mid_state got res %h busy %b rdy %b exp 0 0 1", result, busy, in_ready); end
        seen = 1'b0;
        repeat (40) begin @(negedge clk); if (out_valid !== 1'b0) seen = 1'b1; end
        checks++; if (seen) begin failures++; $display("FAIL reset_mid_no_result got out_valid 1 exp 0"); end
        run_op(3'b000, 32'd3, 32'd4, r, l, s);
        checks++; if (r !== 32'd12 || l != 34) begin failures++; $display("FAIL mul_after_flush got %h lat %0d exp 0000000c lat 34", r, l); end
        take();
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_special();
        test_back_to_back();
        test_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
